// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the little-computer CPU sequencer: instruction
// format, opcode values and the sequencer state encodings.
package cpu_sequencer_pkg;

  localparam int InstrWidth    = 16;
  localparam int AluOpWidth    = 3;
  localparam int OpcodeWidth   = 4;
  localparam int SeqStateWidth = 3;

  typedef enum logic [OpcodeWidth-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_ADDI = 4'h2,
    OP_LSL  = 4'h3,
    OP_BEQ  = 4'h4,
    OP_SUB  = 4'h5,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [SeqStateWidth-1:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_FETCH     = 3'd1,
    SEQ_DECODE    = 3'd2,
    SEQ_EXECUTE   = 3'd3,
    SEQ_WRITEBACK = 3'd4,
    SEQ_HALTED    = 3'd5
  } seq_state_e;

  // Opcode lives in the top bits of every instruction word.
  function automatic logic [OpcodeWidth-1:0] instr_opcode(input logic [InstrWidth-1:0] word);
    return word[InstrWidth-1 -: OpcodeWidth];
  endfunction

endpackage

// File: rtl/cpu_sequencer_perf_counter.sv
// Single 32-bit wrapping event counter with asynchronous reset.
// With ENABLE=0 the output is tied to zero and no flops exist.
module seq_perf_counter #(
  parameter bit ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  if (ENABLE) begin : g_cnt
    // Count one event per enabled cycle, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) count <= '0;
      else if (inc) count <= count + 32'd1;
    end
  end else begin : g_tie
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, rst, inc};
    assign count = '0;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns PC and IR, fetches over a
// req/ack handshake, then steps DECODE -> EXECUTE -> WRITEBACK.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
//
// Handshake: imem_req is held high with imem_addr stable for every FETCH
// cycle; the cycle in which imem_ack is high transfers imem_rdata into the
// IR and ends the fetch. imem_ack in any other state is ignored.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int                   PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_ack,
  input  logic [InstrWidth-1:0]    imem_rdata,
  output logic [InstrWidth-1:0]    instr,
  input  logic                     ctl_halted,
  input  logic                     ctl_reg_write_en,
  input  logic                     ctl_is_beq,
  input  logic                     alu_zero,
  input  logic [PC_WIDTH-1:0]      branch_target,
  output logic                     alu_en,
  output logic                     reg_write,
  output logic [PC_WIDTH-1:0]      pc,
  output logic                     halted,
  output logic [SeqStateWidth-1:0] state,
  output logic [31:0]              cycle_count,
  output logic [31:0]              retired_count
);

  seq_state_e          state_q, state_d;
  logic                taken_q;
  logic                wr_en_q;
  logic [PC_WIDTH-1:0] target_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SEQ_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; run is only looked at in IDLE, HALTED is terminal.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEQ_IDLE:      if (run) state_d = SEQ_FETCH;
      SEQ_FETCH:     if (imem_ack) state_d = SEQ_DECODE;
      SEQ_DECODE:    state_d = ctl_halted ? SEQ_HALTED : SEQ_EXECUTE;
      SEQ_EXECUTE:   state_d = SEQ_WRITEBACK;
      SEQ_WRITEBACK: state_d = SEQ_FETCH;
      SEQ_HALTED:    state_d = SEQ_HALTED;
      default:       state_d = SEQ_IDLE;
    endcase
  end

  // IR load, EXECUTE-time capture of branch decision and write enable,
  // and the PC update on the edge leaving WRITEBACK. Capturing in EXECUTE
  // keeps every output a function of registered state only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      instr    <= '0;
      taken_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      target_q <= '0;
    end else begin
      case (state_q)
        SEQ_FETCH: if (imem_ack) instr <= imem_rdata;
        SEQ_EXECUTE: begin
          taken_q  <= ctl_is_beq & alu_zero;
          wr_en_q  <= ctl_reg_write_en & ~ctl_is_beq;  // BEQ never writes
          target_q <= branch_target;
        end
        SEQ_WRITEBACK: pc <= taken_q ? target_q : pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        default: ;
      endcase
    end
  end

  assign imem_req  = (state_q == SEQ_FETCH);
  assign imem_addr = pc;
  assign alu_en    = (state_q == SEQ_EXECUTE);
  assign reg_write = (state_q == SEQ_WRITEBACK) & wr_en_q;
  assign halted    = (state_q == SEQ_HALTED);
  assign state     = state_q;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic cycle_inc, retire_inc;
  assign cycle_inc  = (state_q != SEQ_IDLE) && (state_q != SEQ_HALTED);
  assign retire_inc = (state_q == SEQ_WRITEBACK);

  seq_perf_counter #(.ENABLE(PerfEn)) u_cycle_cnt (
    .clk(clk), .rst(reset), .inc(cycle_inc), .count(cycle_count)
  );

  seq_perf_counter #(.ENABLE(PerfEn)) u_retire_cnt (
    .clk(clk), .rst(reset), .inc(retire_inc), .count(retired_count)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. A transaction-level model expands
// each program instruction into its expected per-cycle outputs; a compare
// process checks the DUT every cycle against that queue. A few literal
// checks pin the model on the scenarios worked out by hand.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                     clk, reset, run;
  logic                     imem_req, imem_ack;
  logic [15:0]              imem_addr, imem_rdata, instr;
  logic                     ctl_halted, ctl_reg_write_en, ctl_is_beq;
  logic                     alu_zero, alu_en, reg_write, halted;
  logic [15:0]              branch_target, pc;
  logic [SeqStateWidth-1:0] state;
  logic [31:0]              cycle_count, retired_count;

  cpu_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr),
    .ctl_halted(ctl_halted), .ctl_reg_write_en(ctl_reg_write_en),
    .ctl_is_beq(ctl_is_beq), .alu_zero(alu_zero), .branch_target(branch_target),
    .alu_en(alu_en), .reg_write(reg_write), .pc(pc), .halted(halted),
    .state(state), .cycle_count(cycle_count), .retired_count(retired_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stand-in control block ----------------
  logic force_wr;
  logic [3:0] dec_op;
  assign dec_op           = instr[15:12];
  assign ctl_halted       = (dec_op == OP_HALT);
  assign ctl_is_beq       = (dec_op == OP_BEQ);
  assign ctl_reg_write_en = ((dec_op != OP_BEQ) && (dec_op != OP_HALT)) || force_wr;

  // ---------------- program table + memory responder ----------------
  logic [15:0] p_word[8];
  int          p_wait[8];
  logic        p_zero[8];
  logic [15:0] p_tgt[8];
  int          p_n;
  int          r_idx, r_cnt;

  // Answers each fetch after its programmed wait; outside FETCH it drives
  // a junk ack so a DUT that does not ignore it gets caught.
  always @(negedge clk) begin
    if (reset) begin
      imem_ack = 1'b0; r_idx = 0; r_cnt = 0;
    end else if (imem_req) begin
      if (r_cnt >= p_wait[r_idx]) begin
        imem_ack      = 1'b1;
        imem_rdata    = p_word[r_idx];
        alu_zero      = p_zero[r_idx];
        branch_target = p_tgt[r_idx];
        r_idx++; r_cnt = 0;
      end else begin
        imem_ack = 1'b0; imem_rdata = 16'hBEEF; r_cnt++;
      end
    end else begin
      imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0]  st;
    logic        req;
    logic [15:0] addr;
    logic        alu;
    logic        wr;
    logic [15:0] pc;
    logic        hlt;
    logic [15:0] ir;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cmp_e;
  logic [15:0] m_pc, m_ir;
  logic [31:0] m_cyc, m_ret;
  int          n_cmp, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic req, input logic alu,
                      input logic wr, input logic hlt);
    exp_t e;
    e.st = st; e.req = req; e.addr = m_pc; e.alu = alu; e.wr = wr;
    e.pc = m_pc; e.hlt = hlt; e.ir = m_ir;
    e.cyc = PERF ? m_cyc : 32'd0;
    e.ret = PERF ? m_ret : 32'd0;
    exp_q.push_back(e);
    if (st != SEQ_IDLE && st != SEQ_HALTED) m_cyc++;
    if (st == SEQ_WRITEBACK) m_ret++;
  endtask

  // Expand one instruction into its cycles: (wait+1) FETCH, DECODE, then
  // either HALTED forever or EXECUTE, WRITEBACK and the PC update.
  task automatic add_instr(input logic [15:0] word, input int wt,
                           input logic zero, input logic [15:0] tgt);
    logic [3:0] op;
    p_word[p_n] = word; p_wait[p_n] = wt; p_zero[p_n] = zero; p_tgt[p_n] = tgt;
    p_n++;
    for (int i = 0; i <= wt; i++) push(SEQ_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    m_ir = word;
    push(SEQ_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
    op = word[15:12];
    if (op == OP_HALT) begin
      for (int i = 0; i < 3; i++) push(SEQ_HALTED, 1'b0, 1'b0, 1'b0, 1'b1);
    end else begin
      push(SEQ_EXECUTE, 1'b0, 1'b1, 1'b0, 1'b0);
      push(SEQ_WRITEBACK, 1'b0, 1'b0, op != OP_BEQ, 1'b0);
      m_pc = (op == OP_BEQ && zero) ? tgt : m_pc + 16'd1;
    end
  endtask

  // Per-cycle compare against the expected queue.
  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      check("state",     32'(state),         32'(cmp_e.st));
      check("imem_req",  32'(imem_req),      32'(cmp_e.req));
      check("imem_addr", 32'(imem_addr),     32'(cmp_e.addr));
      check("alu_en",    32'(alu_en),        32'(cmp_e.alu));
      check("reg_write", 32'(reg_write),     32'(cmp_e.wr));
      check("pc",        32'(pc),            32'(cmp_e.pc));
      check("halted",    32'(halted),        32'(cmp_e.hlt));
      check("instr",     32'(instr),         32'(cmp_e.ir));
      check("cycle_cnt", cycle_count,        cmp_e.cyc);
      check("retired",   retired_count,      cmp_e.ret);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    m_pc = 16'h0000; m_ir = 16'h0000; m_cyc = 0; m_ret = 0; p_n = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() > 0 && b < 200) begin
      @(negedge clk); b++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  int c;
  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; run = 1'b0; force_wr = 1'b0;
    alu_zero = 1'b0; branch_target = 16'h0; imem_ack = 1'b0; imem_rdata = 16'h0;
    for (int i = 0; i < 8; i++) begin
      p_word[i] = 16'h0; p_wait[i] = 0; p_zero[i] = 1'b0; p_tgt[i] = 16'h0;
    end
    m_pc = 0; m_ir = 0; m_cyc = 0; m_ret = 0; p_n = 0;

    // Reset held with run low for 5 cycles.
    repeat (5) @(negedge clk);
    check("rst_state",   32'(state),    32'(SEQ_IDLE));
    check("rst_pc",      32'(pc),       32'h0);
    check("rst_req",     32'(imem_req), 32'h0);
    check("rst_halted",  32'(halted),   32'h0);
    check("rst_instr",   32'(instr),    32'h0);
    check("rst_strobes", 32'({alu_en, reg_write}), 32'h0);
    check("rst_cnt",     cycle_count | retired_count, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_state",  32'(state), 32'(SEQ_IDLE));
    check("idle_ack_ig", 32'(instr), 32'h0);

    // Program 1: ADD, BEQ taken, BEQ not taken, ADD with 3 waits,
    // BEQ to 0xFFFF, ADD (PC wraps to 0), HALT with 1 wait.
    do_reset();
    force_wr = 1'b1;
    add_instr(16'h1000, 0, 1'b0, 16'h0000);
    add_instr(16'h4012, 0, 1'b1, 16'h0040);
    add_instr(16'h4034, 0, 1'b0, 16'h1234);
    add_instr(16'h1056, 3, 1'b0, 16'h0000);
    add_instr(16'h4078, 0, 1'b1, 16'hFFFF);
    add_instr(16'h109A, 0, 1'b0, 16'h0000);
    add_instr(16'hF000, 1, 1'b0, 16'h0000);
    run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
    c = 1;
    while (!reg_write && c < 20) begin
      @(posedge clk); #1; c++;
    end
    check("first_wr_cycle", 32'(c), 32'd4);
    @(posedge clk); #1;
    check("pc_after_add", 32'(pc), 32'h0001);
    check("fetch2_addr",  32'(imem_addr), 32'h0001);
    wait_drain();
    check("p1_pc_wrap", 32'(pc), 32'h0000);
    check("p1_halted",  32'(halted), 32'h1);
    check("p1_retired", retired_count, PERF ? 32'd6 : 32'd0);
    check("p1_cycles",  cycle_count,   PERF ? 32'd30 : 32'd0);
    force_wr = 1'b0;

    // Program 2: ADDI, LSL, HALT with zero-wait memory.
    do_reset();
    add_instr(16'h2105, 0, 1'b0, 16'h0000);
    add_instr(16'h3201, 0, 1'b0, 16'h0000);
    add_instr(16'hF000, 0, 1'b0, 16'h0000);
    run = 1'b1;
    @(negedge clk); run = 1'b0;
    wait_drain();
    check("p2_pc",      32'(pc),     32'h0002);
    check("p2_halted",  32'(halted), 32'h1);
    check("p2_retired", retired_count, PERF ? 32'd2 : 32'd0);
    check("p2_cycles",  cycle_count,   PERF ? 32'd10 : 32'd0);
    run = 1'b1;
    repeat (3) @(negedge clk);
    run = 1'b0;
    check("p2_frozen_pc", 32'(pc),    32'h0002);
    check("p2_stay_halt", 32'(state), 32'(SEQ_HALTED));

    // Program 3: reset in the middle of a long fetch wait.
    do_reset();
    p_word[0] = 16'h1111; p_wait[0] = 20; p_zero[0] = 1'b0; p_tgt[0] = 16'h0;
    run = 1'b1;
    @(negedge clk); run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("p3_req_before", 32'(imem_req), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("p3_req_drop",  32'(imem_req), 32'h0);
    check("p3_state",     32'(state),    32'(SEQ_IDLE));
    check("p3_pc",        32'(pc),       32'h0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
